// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Provides the default address/data widths, the x0 register index and
// the requester index enum used by the arbiter and its round-robin core.
package regfile_wb_arbiter_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with a last-grant pointer flop.
// Latency: grant is combinational from valid; pointer moves on a completed transfer.
// Backpressure: a non-granted requester simply sees grant low and holds its request.
// Ports: clk/rst (async active-low), valid[1:0] requests, grant[1:0] one-hot grant.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  req_e last;

  // A grant is only ever raised with its own valid, so any grant bit set
  // means a transfer completes at the next edge.
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] && (!valid[1] || (last == REQ_LOAD));
    grant[1] = valid[1] && (!valid[0] || (last == REQ_ALU));
  end

  // Reset to REQ_LOAD so the ALU requester wins the first contest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= REQ_LOAD;
    end else if (grant[0]) begin
      last <= REQ_ALU;
    end else if (grant[1]) begin
      last <= REQ_LOAD;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: arbitrates ALU/load writebacks and tracks pending writes.
// Latency: one cycle from accepted writeback to rf_we/rf_addr/rf_wd; one write per cycle sustained.
// Backpressure: wbN_ready is the round-robin grant; iss_ready drops when a register's pending count saturates.
// Ports: clk/rst (async active-low); iss_* issue handshake; q_rs1/q_rs2/q_stall hazard query;
//        wb0_* (ALU) and wb1_* (load) writeback requests; rf_we/rf_addr/rf_wd to the register file.
module regfile_wb_arbiter #(
  parameter int ADDR_W   = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W   = regfile_wb_arbiter_pkg::DATA_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  output logic              q_stall,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wd
);

  import regfile_wb_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] RZ      = ADDR_W'(REG_ZERO);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [1:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              iss_inc;
  logic [CNT_W-1:0]  cnt [NUM_REGS];

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({wb1_valid, wb0_valid}),
    .grant (grant)
  );

  assign wb0_ready = grant[0];
  assign wb1_ready = grant[1];
  assign xfer      = |grant;
  assign sel_rd    = grant[1] ? wb1_rd   : wb0_rd;
  assign sel_data  = grant[1] ? wb1_data : wb0_data;

  // Writebacks to x0 are consumed but never reach the register file, so
  // they also never decrement a counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_wd   <= '0;
    end else begin
      rf_we <= xfer && (sel_rd != RZ);
      if (xfer) begin
        rf_addr <= sel_rd;
        rf_wd   <= sel_data;
      end
    end
  end

  // Saturation check ignores a same-cycle decrement to keep the ready path
  // independent of the output register.
  assign iss_ready = (iss_rd == RZ) || (cnt[iss_rd] != CNT_MAX);
  assign iss_inc   = iss_valid && iss_ready && (iss_rd != RZ);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic inc;
    logic dec;

    assign inc = iss_inc && (iss_rd == ADDR_W'(r));
    // Decrement on the same edge the register file commits the write.
    assign dec = rf_we && (rf_addr == ADDR_W'(r));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt[r] <= '0;
      end else if (inc && !dec) begin
        cnt[r] <= cnt[r] + CNT_W'(1);
      end else if (dec && !inc && (cnt[r] != '0)) begin
        cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  assign q_stall = ((q_rs1 != RZ) && (cnt[q_rs1] != '0)) ||
                   ((q_rs2 != RZ) && (cnt[q_rs2] != '0));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_stall;
  logic        wb0_valid;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;

  int n_cmp;
  int n_bad;

  logic [31:0] rf_mem [32];

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_stall   (q_stall),
    .wb0_valid (wb0_valid),
    .wb0_rd    (wb0_rd),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_rd    (wb1_rd),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wd     (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file write port: commits at the edge after the arbiter's transfer.
  always @(posedge clk) begin
    if (rf_we && (rf_addr != 5'd0)) rf_mem[rf_addr] <= rf_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rst = 1'b0;
    iss_valid = 1'b0; iss_rd = 5'd5;
    q_rs1 = 5'd5; q_rs2 = 5'd10;
    wb0_valid = 1'b0; wb0_rd = 5'd0; wb0_data = 32'h0;
    wb1_valid = 1'b0; wb1_rd = 5'd0; wb1_data = 32'h0;

    // Reset state and idle.
    repeat (2) @(negedge clk);
    #1;
    check("rst_rf_we",   {31'd0, rf_we}, 32'd0);
    check("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    check("rst_rf_wd",   rf_wd, 32'h0);
    rst = 1'b1;
    #1;
    check("idle_iss_ready", {31'd0, iss_ready}, 32'd1);
    check("idle_q_stall",   {31'd0, q_stall}, 32'd0);

    // Issue r5, then ALU writeback to r5.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1 check("iss_r5_ready", {31'd0, iss_ready}, 32'd1);
    @(negedge clk);
    iss_valid = 1'b0;
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hAAAAAAAA;
    #1;
    check("r5_stall_pending", {31'd0, q_stall}, 32'd1);
    check("wb0_only_ready0",  {31'd0, wb0_ready}, 32'd1);
    check("wb0_only_ready1",  {31'd0, wb1_ready}, 32'd0);
    @(negedge clk);
    wb0_valid = 1'b0;
    #1;
    check("r5_rf_we",        {31'd0, rf_we}, 32'd1);
    check("r5_rf_addr",      {27'd0, rf_addr}, 32'd5);
    check("r5_rf_wd",        rf_wd, 32'hAAAAAAAA);
    check("r5_stall_precommit", {31'd0, q_stall}, 32'd1);
    @(negedge clk);
    #1;
    check("r5_rf_we_idle",   {31'd0, rf_we}, 32'd0);
    check("r5_stall_clear",  {31'd0, q_stall}, 32'd0);
    check("r5_rd1",          rf_mem[5], 32'hAAAAAAAA);
    check("r5_rf_addr_hold", {27'd0, rf_addr}, 32'd5);

    // Load writeback to x0: accepted, no write, no counter change.
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'hFFFFFFFF;
    #1;
    check("x0_wb1_ready", {31'd0, wb1_ready}, 32'd1);
    check("x0_wb0_ready", {31'd0, wb0_ready}, 32'd0);
    @(negedge clk);
    wb1_valid = 1'b0;
    #1;
    check("x0_rf_we",   {31'd0, rf_we}, 32'd0);
    check("x0_q_stall", {31'd0, q_stall}, 32'd0);

    // Round-robin: two pending writes each on r5 and r10, then both requesters valid.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iss_valid = 1'b1;
      iss_rd = (i < 2) ? 5'd5 : 5'd10;
    end
    @(negedge clk);
    iss_valid = 1'b0;
    #1 check("rr_stall_before", {31'd0, q_stall}, 32'd1);
    wb0_valid = 1'b1; wb0_rd = 5'd5;  wb0_data = 32'hBBBBBBBB;
    wb1_valid = 1'b1; wb1_rd = 5'd10; wb1_data = 32'hBBBBBBBB;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("rr_grant0_c%0d", c), {31'd0, wb0_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_grant1_c%0d", c), {31'd0, wb1_ready}, (c % 2 == 0) ? 32'd0 : 32'd1);
      if (c > 0) begin
        check($sformatf("rr_we_c%0d", c),   {31'd0, rf_we}, 32'd1);
        check($sformatf("rr_addr_c%0d", c), {27'd0, rf_addr}, ((c - 1) % 2 == 0) ? 32'd5 : 32'd10);
      end
    end
    @(negedge clk);
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    #1;
    check("rr_we_last",   {31'd0, rf_we}, 32'd1);
    check("rr_addr_last", {27'd0, rf_addr}, 32'd10);
    @(negedge clk);
    #1;
    check("rr_we_idle",     {31'd0, rf_we}, 32'd0);
    check("rr_stall_clear", {31'd0, q_stall}, 32'd0);
    check("rr_rd_r10",      rf_mem[10], 32'hBBBBBBBB);

    // Saturation on r7.
    q_rs1 = 5'd7; q_rs2 = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iss_valid = 1'b1; iss_rd = 5'd7;
      #1 check($sformatf("sat_iss_ready_%0d", i), {31'd0, iss_ready}, 32'd1);
    end
    @(negedge clk);
    #1 check("sat_iss_ready_full", {31'd0, iss_ready}, 32'd0);
    wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h77770001;
    @(negedge clk);
    wb0_data = 32'h77770002;
    #1;
    check("sat_we_pending",    {31'd0, rf_we}, 32'd1);
    check("sat_ready_pending", {31'd0, iss_ready}, 32'd0);
    @(negedge clk);
    wb0_valid = 1'b0;
    #1;
    check("sat_reenable",  {31'd0, iss_ready}, 32'd1);
    check("sat_we_second", {31'd0, rf_we}, 32'd1);
    @(negedge clk);
    #1;
    check("sat_inc_dec_same_edge", {31'd0, iss_ready}, 32'd1);
    check("sat_rd_r7", rf_mem[7], 32'h77770002);
    @(negedge clk);
    iss_valid = 1'b0;
    #1 check("sat_back_at_max", {31'd0, iss_ready}, 32'd0);
    wb0_valid = 1'b1; wb0_data = 32'h77770003;
    repeat (2) @(negedge clk);
    @(negedge clk);
    wb0_valid = 1'b0;
    #1 check("sat_drain_stall", {31'd0, q_stall}, 32'd1);
    @(negedge clk);
    #1;
    check("sat_drained_stall", {31'd0, q_stall}, 32'd0);
    check("sat_drained_ready", {31'd0, iss_ready}, 32'd1);

    // Reset in the middle of a write with pending counts on r5 and r10.
    q_rs1 = 5'd5; q_rs2 = 5'd10;
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd5;
    @(negedge clk);
    iss_rd = 5'd10;
    @(negedge clk);
    iss_valid = 1'b0;
    #1 check("mid_stall_before", {31'd0, q_stall}, 32'd1);
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'h12345678;
    @(negedge clk);
    wb0_valid = 1'b0;
    #1 check("mid_we_before", {31'd0, rf_we}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_we_cleared",   {31'd0, rf_we}, 32'd0);
    check("mid_addr_cleared", {27'd0, rf_addr}, 32'd0);
    check("mid_stall_clear",  {31'd0, q_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h0;
    wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h0;
    #1;
    check("post_rst_grant0", {31'd0, wb0_ready}, 32'd1);
    check("post_rst_grant1", {31'd0, wb1_ready}, 32'd0);
    @(negedge clk);
    wb0_valid = 1'b0; wb1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
